// File: rtl/mf_disp_cmd_regfile.sv
// Command/status register file for the display interface: decodes the command bus into
// a double-buffered CTL0, CTL1 pulse strobes, W1C status, IRQ and a frame counter.
module mf_disp_cmd_regfile #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 8,
    parameter int FRM_CNT_W = 16
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              cmd_wr_vld,
    input  logic [ADDR_W-1:0] cmd_wr_addr,
    input  logic [DATA_W-1:0] cmd_wr_data,
    input  logic              cmd_rd_vld,
    input  logic [ADDR_W-1:0] cmd_rd_addr,
    output logic              cmd_rd_ack,
    output logic [DATA_W-1:0] cmd_rd_data,
    input  logic              evt_frame_start,
    input  logic              evt_frame_done,
    input  logic              evt_underflow,
    output logic              cmd_intf_enabled,
    output logic              cmd_intf_pix_dm,
    output logic              cmd_intf_tm,
    output logic              cmd_intf_frame_switch,
    output logic              cmd_intf_frame_restrt,
    output logic              cmd_irq
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] IDX_CTL0    = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_CTL1    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_STAT    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_IRQ_EN  = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_FRM_CNT = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(5);

    typedef struct packed {
        logic underflow;
        logic frame_done;
    } stat_t;

    // ---------------- address decode ----------------
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_map, rd_map;
    logic             wr_ctl0, wr_ctl1, wr_stat, wr_irq_en, wr_scratch;

    assign wr_idx = cmd_wr_addr[ADDR_W-1:2];
    assign rd_idx = cmd_rd_addr[ADDR_W-1:2];
    assign wr_map = cmd_wr_vld && (cmd_wr_addr[1:0] == 2'b00) && (32'(wr_idx) < 32'(NUM_REGS));
    assign rd_map = (cmd_rd_addr[1:0] == 2'b00) && (32'(rd_idx) < 32'(NUM_REGS));

    assign wr_ctl0    = wr_map && (wr_idx == IDX_CTL0);
    assign wr_ctl1    = wr_map && (wr_idx == IDX_CTL1);
    assign wr_stat    = wr_map && (wr_idx == IDX_STAT);
    assign wr_irq_en  = wr_map && (wr_idx == IDX_IRQ_EN);
    assign wr_scratch = wr_map && (wr_idx == IDX_SCRATCH);

    // ---------------- state ----------------
    logic [2:0]           ctl0_shadow_q, ctl0_shadow_d;
    logic [2:0]           ctl0_active_q, ctl0_active_d;
    logic                 ctl0_pend_q, ctl0_pend_d;
    logic                 frame_switch_q, frame_switch_d;
    logic                 frame_restrt_q, frame_restrt_d;
    stat_t                stat_q, stat_d;
    logic [1:0]           irq_en_q, irq_en_d;
    logic [FRM_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0]    scratch_q, scratch_d;
    logic                 irq_q, irq_d;
    logic                 rd_ack_q, rd_ack_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic [DATA_W-1:0]    rd_val;

    always_comb begin
        ctl0_shadow_d = ctl0_shadow_q;
        ctl0_active_d = ctl0_active_q;
        ctl0_pend_d   = ctl0_pend_q;
        if (wr_ctl0) begin
            ctl0_shadow_d = cmd_wr_data[2:0];
            // Disabled interface, or a write landing on the frame boundary, commits at once.
            if (!ctl0_active_q[0] || evt_frame_start) begin
                ctl0_active_d = cmd_wr_data[2:0];
                ctl0_pend_d   = 1'b0;
            end else begin
                ctl0_pend_d   = 1'b1;
            end
        end else if (evt_frame_start && ctl0_pend_q) begin
            ctl0_active_d = ctl0_shadow_q;
            ctl0_pend_d   = 1'b0;
        end
    end

    always_comb begin
        frame_switch_d = wr_ctl1 && cmd_wr_data[0];
        frame_restrt_d = wr_ctl1 && cmd_wr_data[1];

        // Event set takes priority over a simultaneous W1C clear.
        stat_d.frame_done = evt_frame_done ||
                            (stat_q.frame_done && !(wr_stat && cmd_wr_data[0]));
        stat_d.underflow  = evt_underflow ||
                            (stat_q.underflow && !(wr_stat && cmd_wr_data[1]));

        irq_en_d    = wr_irq_en ? cmd_wr_data[1:0] : irq_en_q;
        scratch_d   = wr_scratch ? cmd_wr_data : scratch_q;
        frame_cnt_d = evt_frame_done ? frame_cnt_q + FRM_CNT_W'(1) : frame_cnt_q;
        irq_d       = |({stat_q.underflow, stat_q.frame_done} & irq_en_q);
    end

    // Read mux sees current register values, so a same-cycle write returns pre-write data.
    always_comb begin
        rd_val = '0;
        if (rd_map) begin
            case (rd_idx)
                IDX_CTL0:    rd_val = DATA_W'(ctl0_shadow_q);
                IDX_STAT:    rd_val = DATA_W'({ctl0_pend_q, stat_q.underflow, stat_q.frame_done});
                IDX_IRQ_EN:  rd_val = DATA_W'(irq_en_q);
                IDX_FRM_CNT: rd_val = DATA_W'(frame_cnt_q);
                IDX_SCRATCH: rd_val = scratch_q;
                default:     rd_val = '0;
            endcase
        end
    end

    always_comb begin
        rd_ack_d  = cmd_rd_vld;
        rd_data_d = cmd_rd_vld ? rd_val : rd_data_q;
    end

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            ctl0_shadow_q  <= '0;
            ctl0_active_q  <= '0;
            ctl0_pend_q    <= 1'b0;
            frame_switch_q <= 1'b0;
            frame_restrt_q <= 1'b0;
            stat_q         <= '0;
            irq_en_q       <= '0;
            frame_cnt_q    <= '0;
            scratch_q      <= '0;
            irq_q          <= 1'b0;
            rd_ack_q       <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            ctl0_shadow_q  <= ctl0_shadow_d;
            ctl0_active_q  <= ctl0_active_d;
            ctl0_pend_q    <= ctl0_pend_d;
            frame_switch_q <= frame_switch_d;
            frame_restrt_q <= frame_restrt_d;
            stat_q         <= stat_d;
            irq_en_q       <= irq_en_d;
            frame_cnt_q    <= frame_cnt_d;
            scratch_q      <= scratch_d;
            irq_q          <= irq_d;
            rd_ack_q       <= rd_ack_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign cmd_intf_enabled      = ctl0_active_q[0];
    assign cmd_intf_pix_dm       = ctl0_active_q[1];
    assign cmd_intf_tm           = ctl0_active_q[2];
    assign cmd_intf_frame_switch = frame_switch_q;
    assign cmd_intf_frame_restrt = frame_restrt_q;
    assign cmd_irq               = irq_q;
    assign cmd_rd_ack            = rd_ack_q;
    assign cmd_rd_data           = rd_data_q;

endmodule

// File: tb/tb_mf_disp_cmd_regfile.sv
// Directed plus random bench for mf_disp_cmd_regfile against a behavioural register model.
module tb_mf_disp_cmd_regfile;

    logic        sys_clk = 1'b0;
    logic        resetn  = 1'b0;
    logic        cmd_wr_vld = 1'b0;
    logic [7:0]  cmd_wr_addr = '0;
    logic [31:0] cmd_wr_data = '0;
    logic        cmd_rd_vld = 1'b0;
    logic [7:0]  cmd_rd_addr = '0;
    logic        cmd_rd_ack;
    logic [31:0] cmd_rd_data;
    logic        evt_frame_start = 1'b0, evt_frame_done = 1'b0, evt_underflow = 1'b0;
    logic        cmd_intf_enabled, cmd_intf_pix_dm, cmd_intf_tm;
    logic        cmd_intf_frame_switch, cmd_intf_frame_restrt, cmd_irq;

    always #5 sys_clk = ~sys_clk;

    mf_disp_cmd_regfile dut (
        .sys_clk(sys_clk), .resetn(resetn),
        .cmd_wr_vld(cmd_wr_vld), .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
        .cmd_rd_vld(cmd_rd_vld), .cmd_rd_addr(cmd_rd_addr),
        .cmd_rd_ack(cmd_rd_ack), .cmd_rd_data(cmd_rd_data),
        .evt_frame_start(evt_frame_start), .evt_frame_done(evt_frame_done),
        .evt_underflow(evt_underflow),
        .cmd_intf_enabled(cmd_intf_enabled), .cmd_intf_pix_dm(cmd_intf_pix_dm),
        .cmd_intf_tm(cmd_intf_tm), .cmd_intf_frame_switch(cmd_intf_frame_switch),
        .cmd_intf_frame_restrt(cmd_intf_frame_restrt), .cmd_irq(cmd_irq)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: register contents as the programmer sees them.
    logic [2:0]  m_shadow, m_active;
    logic        m_pend, m_sw, m_rs, m_fd, m_uf, m_irq, m_ack;
    logic [1:0]  m_irq_en;
    int unsigned m_cnt;
    logic [31:0] m_scr, m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        if (a[1:0] != 2'b00 || a >= 8'h20) return 32'h0;
        case (a)
            8'h00:   return {29'b0, m_shadow};
            8'h08:   return {29'b0, m_pend, m_uf, m_fd};
            8'h0C:   return {30'b0, m_irq_en};
            8'h10:   return m_cnt;
            8'h14:   return m_scr;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_shadow = 0; m_active = 0; m_pend = 0; m_sw = 0; m_rs = 0; m_fd = 0; m_uf = 0;
        m_irq = 0; m_ack = 0; m_irq_en = 0; m_cnt = 0; m_scr = 0; m_rdata = 0;
    endtask

    task automatic m_step(input logic wv, input logic [7:0] wa, input logic [31:0] wd,
                          input logic rv, input logic [7:0] ra,
                          input logic fs, input logic fd, input logic uf);
        logic mapped;
        logic [31:0] rval;
        mapped = wv && (wa[1:0] == 2'b00) && (wa < 8'h20);
        rval   = m_read(ra);
        m_irq  = (m_fd && m_irq_en[0]) || (m_uf && m_irq_en[1]);
        m_sw   = mapped && wa == 8'h04 && wd[0];
        m_rs   = mapped && wa == 8'h04 && wd[1];
        if (mapped && wa == 8'h00) begin
            m_shadow = wd[2:0];
            if (!m_active[0] || fs) begin m_active = wd[2:0]; m_pend = 0; end
            else m_pend = 1;
        end else if (fs && m_pend) begin
            m_active = m_shadow; m_pend = 0;
        end
        if (mapped && wa == 8'h08 && wd[0]) m_fd = 0;
        if (mapped && wa == 8'h08 && wd[1]) m_uf = 0;
        if (fd) m_fd = 1;
        if (uf) m_uf = 1;
        if (fd) m_cnt = (m_cnt + 1) % 65536;
        if (mapped && wa == 8'h0C) m_irq_en = wd[1:0];
        if (mapped && wa == 8'h14) m_scr = wd;
        m_ack = rv;
        if (rv) m_rdata = rval;
    endtask

    task automatic check_all();
        chk("intf_enabled", 32'(cmd_intf_enabled), 32'(m_active[0]));
        chk("intf_pix_dm", 32'(cmd_intf_pix_dm), 32'(m_active[1]));
        chk("intf_tm", 32'(cmd_intf_tm), 32'(m_active[2]));
        chk("frame_switch", 32'(cmd_intf_frame_switch), 32'(m_sw));
        chk("frame_restrt", 32'(cmd_intf_frame_restrt), 32'(m_rs));
        chk("irq", 32'(cmd_irq), 32'(m_irq));
        chk("rd_ack", 32'(cmd_rd_ack), 32'(m_ack));
        chk("rd_data", cmd_rd_data, m_rdata);
    endtask

    task automatic cyc(input logic wv, input logic [7:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [7:0] ra,
                       input logic fs, input logic fd, input logic uf);
        cmd_wr_vld = wv; cmd_wr_addr = wa; cmd_wr_data = wd;
        cmd_rd_vld = rv; cmd_rd_addr = ra;
        evt_frame_start = fs; evt_frame_done = fd; evt_underflow = uf;
        @(posedge sys_clk);
        m_step(wv, wa, wd, rv, ra, fs, fd, uf);
        #1;
        check_all();
        cmd_wr_vld = 0; cmd_rd_vld = 0;
        evt_frame_start = 0; evt_frame_done = 0; evt_underflow = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cyc(1, a, d, 0, 8'h00, 0, 0, 0);
    endtask
    task automatic idle();
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    endtask
    task automatic rd_exp(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cyc(0, 8'h00, 0, 1, a, 0, 0, 0);
        chk(tag, cmd_rd_data, exp);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #3;
        m_reset();
        check_all();
        chk("reset_rd_data", cmd_rd_data, 32'h0);
        @(negedge sys_clk);
        resetn = 1'b1;
    endtask

    logic [7:0] addr_tbl [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                                  8'h18, 8'h1C, 8'h20, 8'h24, 8'h02, 8'hFF};

    initial begin
        do_reset();

        // Reset values and unmapped/misaligned accesses
        for (int a = 0; a < 32; a += 4) rd_exp("reset_read", 8'(a), 32'h0);
        rd_exp("misaligned_read", 8'h02, 32'h0);
        wr(8'h20, 32'hFFFF_FFFF);
        wr(8'h15, 32'hFFFF_FFFF);
        for (int a = 0; a < 32; a += 4) rd_exp("after_unmapped_wr", 8'(a), 32'h0);

        // CTL0 while disabled commits immediately
        wr(8'h00, 32'h5);
        chk("ctl0_direct", {29'b0, cmd_intf_tm, cmd_intf_pix_dm, cmd_intf_enabled}, 32'h5);
        rd_exp("stat_no_pend", 8'h08, 32'h0);

        // Enabled: held until frame start
        wr(8'h00, 32'h3);
        chk("ctl0_held", {29'b0, cmd_intf_tm, cmd_intf_pix_dm, cmd_intf_enabled}, 32'h5);
        rd_exp("stat_pend", 8'h08, 32'h4);
        rd_exp("ctl0_shadow", 8'h00, 32'h3);
        cyc(0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        chk("ctl0_commit", {29'b0, cmd_intf_tm, cmd_intf_pix_dm, cmd_intf_enabled}, 32'h3);
        rd_exp("stat_pend_clr", 8'h08, 32'h0);
        cyc(1, 8'h00, 32'h7, 0, 8'h00, 1, 0, 0);
        chk("ctl0_same_cycle", {29'b0, cmd_intf_tm, cmd_intf_pix_dm, cmd_intf_enabled}, 32'h7);
        rd_exp("stat_same_cycle", 8'h08, 32'h0);

        // CTL1 pulses
        wr(8'h04, 32'h3);
        chk("pulse_both", {30'b0, cmd_intf_frame_restrt, cmd_intf_frame_switch}, 32'h3);
        idle();
        chk("pulse_one_cycle", {30'b0, cmd_intf_frame_restrt, cmd_intf_frame_switch}, 32'h0);
        wr(8'h04, 32'h0);
        chk("pulse_none", {30'b0, cmd_intf_frame_restrt, cmd_intf_frame_switch}, 32'h0);
        wr(8'h04, 32'h1);
        wr(8'h04, 32'h2);
        chk("pulse_b2b", {30'b0, cmd_intf_frame_restrt, cmd_intf_frame_switch}, 32'h2);
        rd_exp("ctl1_reads0", 8'h04, 32'h0);

        // Sticky status and IRQ
        wr(8'h0C, 32'h1);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        rd_exp("stat_fd_set", 8'h08, 32'h1);
        chk("irq_set", 32'(cmd_irq), 32'h1);
        cyc(1, 8'h08, 32'h1, 0, 8'h00, 0, 1, 0);
        rd_exp("stat_set_wins", 8'h08, 32'h1);
        wr(8'h08, 32'h0);
        rd_exp("stat_w0_noeffect", 8'h08, 32'h1);
        wr(8'h08, 32'h1);
        idle();
        chk("irq_drop", 32'(cmd_irq), 32'h0);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        idle();
        rd_exp("stat_uf", 8'h08, 32'h2);
        chk("irq_uf_masked", 32'(cmd_irq), 32'h0);

        // Read/write collision returns pre-write value; scratch full width
        wr(8'h14, 32'hA5A5_1234);
        cyc(1, 8'h14, 32'h0BAD_F00D, 1, 8'h14, 0, 0, 0);
        chk("rw_collision", cmd_rd_data, 32'hA5A5_1234);
        rd_exp("scratch", 8'h14, 32'h0BAD_F00D);
        idle();
        chk("rd_data_hold", cmd_rd_data, 32'h0BAD_F00D);

        // Reset mid-operation: pending lost, no commit afterward
        wr(8'h00, 32'h6);
        do_reset();
        cyc(0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        chk("no_commit_after_rst", {29'b0, cmd_intf_tm, cmd_intf_pix_dm, cmd_intf_enabled}, 32'h0);
        rd_exp("stat_after_rst", 8'h08, 32'h0);

        // Frame counter wrap
        for (int i = 0; i < 65536 + 3; i++) cyc(0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        rd_exp("frame_cnt_wrap", 8'h10, 32'h3);
        wr(8'h10, 32'hFFFF);
        rd_exp("frame_cnt_ro", 8'h10, 32'h3);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d = d & 32'h7;
            cyc(1'($urandom_range(0, 1)), addr_tbl[$urandom_range(0, 11)], d,
                1'($urandom_range(0, 4) != 0), addr_tbl[$urandom_range(0, 11)],
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 6) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mf_disp_cmd_regfile.md
Name: mf_disp_cmd_regfile

Overview:
Parametrised command/status register file for the display interface. It decodes a generic write/read bus into control outputs, pulse strobes, W1C sticky status, an interrupt and a frame counter. CTL0 is double-buffered so mode changes made while the interface is enabled take effect only at a frame boundary. It sits between the bus address decoder and the display timing/pixel pipeline.

Parameters:
ADDR_W, 8, byte-address width of the command bus
DATA_W, 32, data width of the command bus (minimum 16)
NUM_REGS, 8, number of decoded word registers; addresses at or above 4*NUM_REGS are unmapped (minimum 6)
FRM_CNT_W, 16, frame counter width (at most DATA_W)

Ports:
sys_clk  in  1  system clock, all logic rising-edge
resetn  in  1  asynchronous active-low reset
cmd_wr_vld  in  1  write strobe, one write per cycle
cmd_wr_addr  in  ADDR_W  write byte address
cmd_wr_data  in  DATA_W  write data
cmd_rd_vld  in  1  read strobe
cmd_rd_addr  in  ADDR_W  read byte address
cmd_rd_ack  out  1  read data valid, 1 cycle after cmd_rd_vld
cmd_rd_data  out  DATA_W  read data, qualified by cmd_rd_ack
evt_frame_start  in  1  one-cycle pulse at start of each frame (commit point)
evt_frame_done  in  1  one-cycle pulse at end of each frame
evt_underflow  in  1  one-cycle pulse on pixel FIFO underflow
cmd_intf_enabled  out  1  active CTL0[0]
cmd_intf_pix_dm  out  1  active CTL0[1], pixel doubling
cmd_intf_tm  out  1  active CTL0[2], test pattern
cmd_intf_frame_switch  out  1  registered one-cycle pulse
cmd_intf_frame_restrt  out  1  registered one-cycle pulse
cmd_irq  out  1  registered level interrupt

Behaviour:
- Reset is resetn, asynchronous, active-low. Clock is sys_clk. At reset every register and output is 0, including the active CTL0, the shadow CTL0, the pending flag, the pulses, the STAT bits, IRQ_EN, FRAME_CNT, SCRATCH, cmd_rd_ack, cmd_rd_data and cmd_irq.
- Address decode:
  - A write or read is mapped only when addr[1:0]==0 and addr[ADDR_W-1:2] < NUM_REGS.
  - Unmapped or misaligned writes are ignored.
  - Unmapped or misaligned reads still ack and return 0.
  - Unused bits of mapped registers read as 0.
- Register map:
  - 0x00 CTL0 RW [2:0].
  - 0x04 CTL1 write-only pulse; reads 0.
  - 0x08 STAT: [0] FRAME_DONE W1C, [1] UNDERFLOW W1C, [2] CTL0_PENDING RO.
  - 0x0C IRQ_EN RW [1:0].
  - 0x10 FRAME_CNT RO [FRM_CNT_W-1:0].
  - 0x14 SCRATCH RW, full DATA_W.
  - 0x18 and above: reserved, reads 0.
- CTL0 double buffering:
  - A write always loads the shadow CTL0; reading 0x00 returns the shadow.
  - If the active enable bit is 0 when written, the active CTL0 loads the written value at the same edge and pending stays 0.
  - Otherwise pending is set to 1, and the active CTL0 loads the shadow on the next evt_frame_start; pending clears at that edge.
  - A CTL0 write in the same cycle as evt_frame_start commits the written value directly and clears pending.
  - Outputs come straight from the active register: 1 cycle after the commit edge.
- CTL1 pulses: a write to 0x04 with data[0]=1 asserts frame_switch, and with data[1]=1 asserts frame_restrt. Each is asserted exactly one cycle, the cycle after the write; both may assert together. Back-to-back writes give back-to-back pulses.
- STAT sticky bits:
  - Set by the corresponding evt pulse.
  - Cleared by writing 1 to that bit at 0x08; writing 0 has no effect.
  - An event in the same cycle as a clear: the set wins and the bit stays 1.
- FRAME_CNT: increments by 1 on each evt_frame_done, wraps modulo 2^FRM_CNT_W. It is not writable; writes to it are ignored.
- IRQ: cmd_irq is a register loaded each cycle with |(STAT[1:0] & IRQ_EN[1:0]), so it reflects register state with 1 cycle latency.
- Read timing: cmd_rd_data and cmd_rd_ack are registered, 1-cycle latency, with full throughput. A read and a write to the same address in the same cycle return the pre-write value. cmd_rd_data holds its last value when ack is 0.
- Reset mid-operation: pending, pulses and status are lost; no commit occurs on the first evt_frame_start after reset unless CTL0 is written again.

Test Plan:
- Reset, then read every address 0x00..0x1C → all ack with 0. Read 0x02 (misaligned) → ack, 0. Write 0x20 with NUM_REGS=8 → no state change.
- CTL0=0x0 (disabled): write 0x00=0x5 → cmd_intf_enabled=1 and tm=1 the cycle after the write, STAT[2]=0.
- Enabled: write 0x00=0x3 → outputs stay 0x5 and STAT[2]=1. Pulse evt_frame_start → outputs become 0x3 the next cycle and STAT[2]=0. Write + frame_start in the same cycle → immediate commit.
- Write 0x04=0x3 → frame_switch and frame_restrt both high for exactly 1 cycle after the write. Write 0x04=0x0 → no pulse.
- IRQ_EN=0x1, evt_frame_done → STAT[0]=1 and cmd_irq=1 a cycle later. Write 0x08=0x1 in the same cycle as another evt_frame_done → STAT[0] stays 1. Clear alone → cmd_irq drops. Underflow with IRQ_EN[1]=0 → STAT[1]=1, cmd_irq=0.
- 2^16+3 evt_frame_done pulses with FRM_CNT_W=16 → FRAME_CNT reads 3. Write 0x10=0xFFFF → value unchanged.
